// File: rtl/user_interrupt_controller_pkg.sv
// Shared register offsets, mode encodings and address decode helper
// for the user interrupt controller.
// Pure declarations; no logic of its own.
package user_interrupt_controller_pkg;

  // Register offsets relative to BASE_ADDRESS
  localparam logic [1:0] IRQ_ENABLE  = 2'd0;
  localparam logic [1:0] IRQ_MODE    = 2'd1;
  localparam logic [1:0] IRQ_PENDING = 2'd2;
  localparam logic [1:0] IRQ_RAW     = 2'd3;

  // Per-source capture mode, stored one bit per source in IRQ_MODE
  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } irq_mode_e;

  // True when addr falls inside the four-register window starting at base.
  // Subtraction wraps, so addresses below base never alias into the window.
  function automatic logic in_window(input logic [11:0] addr, input logic [11:0] base);
    logic [11:0] off;
    off = addr - base;
    return off < 12'd4;
  endfunction

endpackage

// File: rtl/user_interrupt_controller_irq_synchronizer.sv
// Multi-stage flop chain bringing asynchronous lines into the clk domain.
// Latency: STAGES clock edges from din to dout.
// No handshake; every stage advances every cycle.
module irq_synchronizer #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] chain [STAGES];

  // Shift the raw lines through the chain; reset clears every stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign dout = chain[STAGES-1];

endmodule

// File: rtl/user_interrupt_controller.sv
// Synchronises, captures (level or rising edge), latches and masks peripheral
// interrupt lines into the trap unit's userInterrupts vector.
// Latency: SYNC_STAGES+1 edges from irqIn to userInterrupts; CSR reads are combinational.
module user_interrupt_controller
  import user_interrupt_controller_pkg::*;
#(
  parameter int          SOURCES      = 16,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [11:0] BASE_ADDRESS = 12'hBC0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csrWriteEnable,
  input  logic               csrReadEnable,
  input  logic [11:0]        csrWriteAddress,
  input  logic [11:0]        csrReadAddress,
  input  logic [31:0]        csrWriteData,
  output logic [31:0]        csrReadData,
  output logic               requestOutput,
  input  logic [SOURCES-1:0] irqIn,
  output logic [15:0]        userInterrupts
);

  logic [SOURCES-1:0] sync;
  logic [SOURCES-1:0] prev;
  logic [SOURCES-1:0] enable;
  logic [SOURCES-1:0] mode;
  logic [SOURCES-1:0] pending;
  logic [SOURCES-1:0] rise;
  logic [SOURCES-1:0] w1c;
  logic [SOURCES-1:0] wr_data;
  logic [SOURCES-1:0] read_val;
  logic [11:0]        wr_off;
  logic [11:0]        rd_off;
  logic               wr_hit;
  logic               rd_hit;
  logic               unused_wdata_bits;

  irq_synchronizer #(
    .WIDTH  (SOURCES),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (irqIn),
    .dout (sync)
  );

  assign wr_off  = csrWriteAddress - BASE_ADDRESS;
  assign rd_off  = csrReadAddress - BASE_ADDRESS;
  assign wr_hit  = csrWriteEnable && in_window(csrWriteAddress, BASE_ADDRESS);
  assign rd_hit  = csrReadEnable && in_window(csrReadAddress, BASE_ADDRESS);
  assign wr_data = csrWriteData[SOURCES-1:0];

  // Bits above SOURCES are write-ignored by design
  assign unused_wdata_bits = &{1'b0, csrWriteData};

  // Write-1-to-clear only reaches edge-mode bits; level bits follow the line
  assign w1c  = (wr_hit && wr_off[1:0] == IRQ_PENDING) ? (wr_data & mode) : '0;
  assign rise = sync & ~prev;

  // Configuration registers, edge history and the pending latch
  always_ff @(posedge clk) begin
    if (rst) begin
      prev    <= '0;
      enable  <= '0;
      mode    <= '0;
      pending <= '0;
    end else begin
      prev <= sync;
      if (wr_hit && wr_off[1:0] == IRQ_ENABLE) enable <= wr_data;
      if (wr_hit && wr_off[1:0] == IRQ_MODE)   mode   <= wr_data;
      // Mode in effect this cycle decides the update; a new rise beats a clear
      for (int i = 0; i < SOURCES; i++) begin
        if (mode[i] == MODE_EDGE) pending[i] <= rise[i] | (pending[i] & ~w1c[i]);
        else                      pending[i] <= sync[i];
      end
    end
  end

  // Combinational CSR read mux; zero whenever this block is not addressed
  always_comb begin
    read_val = '0;
    if (rd_hit) begin
      case (rd_off[1:0])
        IRQ_ENABLE:  read_val = enable;
        IRQ_MODE:    read_val = mode;
        IRQ_PENDING: read_val = pending;
        default:     read_val = sync;
      endcase
    end
  end

  assign requestOutput  = rd_hit;
  assign csrReadData    = 32'(read_val);
  assign userInterrupts = 16'(pending & enable);

endmodule

// File: tb/tb_user_interrupt_controller.sv
// Self-checking bench: directed vector table, then randomised traffic against
// a cycle-level behavioural model; a SOURCES=4 instance runs alongside.
module tb_user_interrupt_controller;

  localparam logic [11:0] BASE = 12'hBC0;
  localparam int          SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [11:0] wa = BASE, ra = BASE;
  logic [31:0] wd = '0;
  logic [15:0] irq = '0;

  logic [31:0] rd16, rd4;
  logic        req16, req4;
  logic [15:0] ui16, ui4;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  user_interrupt_controller #(.SOURCES(16), .SYNC_STAGES(SYNC), .BASE_ADDRESS(BASE)) u16 (
    .clk(clk), .rst(rst), .csrWriteEnable(we), .csrReadEnable(re),
    .csrWriteAddress(wa), .csrReadAddress(ra), .csrWriteData(wd),
    .csrReadData(rd16), .requestOutput(req16), .irqIn(irq), .userInterrupts(ui16)
  );

  user_interrupt_controller #(.SOURCES(4), .SYNC_STAGES(SYNC), .BASE_ADDRESS(BASE)) u4 (
    .clk(clk), .rst(rst), .csrWriteEnable(we), .csrReadEnable(re),
    .csrWriteAddress(wa), .csrReadAddress(ra), .csrWriteData(wd),
    .csrReadData(rd4), .requestOutput(req4), .irqIn(irq[3:0]), .userInterrupts(ui4)
  );

  // ---------------- behavioural reference model ----------------
  logic [15:0] m_en = '0, m_mode = '0, m_pend = '0, m_prev = '0;
  logic [15:0] m_line [$];   // delayed copies of irq; back entry is the synchronised level

  function automatic logic [15:0] m_sync();
    return m_line[$];
  endfunction

  task automatic model_edge();
    logic [15:0] s;
    int off;
    if (rst) begin
      m_en = '0; m_mode = '0; m_pend = '0; m_prev = '0;
      m_line.delete();
      for (int i = 0; i < SYNC; i++) m_line.push_back(16'h0);
    end else begin
      s = m_sync();
      off = int'(wa) - int'(BASE);
      for (int b = 0; b < 16; b++) begin
        if (!m_mode[b]) m_pend[b] = s[b];
        else if (s[b] && !m_prev[b]) m_pend[b] = 1'b1;
        else if (we && off == 2 && wd[b]) m_pend[b] = 1'b0;
      end
      if (we && off == 0) m_en = wd[15:0];
      if (we && off == 1) m_mode = wd[15:0];
      m_prev = s;
      void'(m_line.pop_back());
      m_line.push_front(irq);
    end
  endtask

  function automatic logic [31:0] model_read();
    int off;
    off = int'(ra) - int'(BASE);
    if (!re) return 32'h0;
    case (off)
      0: return {16'h0, m_en};
      1: return {16'h0, m_mode};
      2: return {16'h0, m_pend};
      3: return {16'h0, m_sync()};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_req();
    int off;
    off = int'(ra) - int'(BASE);
    return re && off >= 0 && off <= 3;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic        re;
    logic [11:0] ra;
    logic [15:0] irq;
    logic [15:0] ui;
    logic [31:0] rd;
    logic        req;
  } vec_t;

  function automatic vec_t v(logic r, logic w, logic [11:0] a, logic [31:0] d, logic rr,
                             logic [11:0] raddr, logic [15:0] i, logic [15:0] u,
                             logic [31:0] q, logic rq);
    vec_t t;
    t.rst = r; t.we = w; t.wa = a; t.wd = d; t.re = rr; t.ra = raddr;
    t.irq = i; t.ui = u; t.rd = q; t.req = rq;
    return t;
  endfunction

  vec_t tbl [$];

  initial begin
    //                rst we  waddr    wdata        re  raddr    irq       ui        rd            req
    // reset with every line high, then release and watch RAW/PENDING fill
    tbl.push_back(v(1, 0, BASE,   32'h0,        1, BASE+3, 16'hFFFF, 16'h0000, 32'h0000_0000, 1));
    tbl.push_back(v(1, 0, BASE,   32'h0,        1, BASE+2, 16'hFFFF, 16'h0000, 32'h0000_0000, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+3, 16'hFFFF, 16'h0000, 32'h0000_0000, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+3, 16'hFFFF, 16'h0000, 32'h0000_FFFF, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'hFFFF, 16'h0000, 32'h0000_FFFF, 1));
    // level path on bit 0: enable, then drop every line; clears three edges later
    tbl.push_back(v(0, 1, BASE,   32'h1,        1, BASE,   16'hFFFF, 16'h0001, 32'h0000_0001, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE,   16'h0000, 16'h0001, 32'h0000_0001, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE,   16'h0000, 16'h0001, 32'h0000_0001, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0000, 16'h0000, 32'h0000_0000, 1));
    // decode: out-of-window read, no read strobe, write to read-only RAW
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+4, 16'h0000, 16'h0000, 32'h0000_0000, 0));
    tbl.push_back(v(0, 0, BASE,   32'h0,        0, BASE,   16'h0000, 16'h0000, 32'h0000_0000, 0));
    tbl.push_back(v(0, 1, BASE+3, 32'hFFFF,     1, BASE+3, 16'h0000, 16'h0000, 32'h0000_0000, 1));
    // edge capture on bit 4: two-cycle pulse, latch persists, then W1C
    tbl.push_back(v(0, 1, BASE+1, 32'h10,       1, BASE+1, 16'h0000, 16'h0000, 32'h0000_0010, 1));
    tbl.push_back(v(0, 1, BASE,   32'h10,       1, BASE,   16'h0000, 16'h0000, 32'h0000_0010, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0010, 16'h0000, 32'h0000_0000, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0010, 16'h0000, 32'h0000_0000, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0000, 16'h0010, 32'h0000_0010, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0000, 16'h0010, 32'h0000_0010, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0000, 16'h0010, 32'h0000_0010, 1));
    tbl.push_back(v(0, 1, BASE+2, 32'h10,       1, BASE+2, 16'h0000, 16'h0000, 32'h0000_0000, 1));
    // set beats clear: W1C lands on the same edge the new rise is detected
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0010, 16'h0000, 32'h0000_0000, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0010, 16'h0000, 32'h0000_0000, 1));
    tbl.push_back(v(0, 1, BASE+2, 32'h10,       1, BASE+2, 16'h0010, 16'h0010, 32'h0000_0010, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0000, 16'h0010, 32'h0000_0010, 1));
    // masking: disable all, capture edge on bit 9 while masked, then enable it
    tbl.push_back(v(0, 1, BASE,   32'h0,        1, BASE+2, 16'h0000, 16'h0000, 32'h0000_0010, 1));
    tbl.push_back(v(0, 1, BASE+1, 32'h210,      1, BASE+2, 16'h0200, 16'h0000, 32'h0000_0010, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0200, 16'h0000, 32'h0000_0010, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        1, BASE+2, 16'h0000, 16'h0000, 32'h0000_0210, 1));
    tbl.push_back(v(0, 1, BASE,   32'h200,      1, BASE,   16'h0000, 16'h0200, 32'h0000_0200, 1));
    tbl.push_back(v(0, 1, BASE+3, 32'hFFFF,     1, BASE+2, 16'h0000, 16'h0200, 32'h0000_0210, 1));
    tbl.push_back(v(0, 0, BASE,   32'h0,        0, BASE+2, 16'h0000, 16'h0200, 32'h0000_0000, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; we = tbl[k].we; wa = tbl[k].wa; wd = tbl[k].wd;
      re = tbl[k].re; ra = tbl[k].ra; irq = tbl[k].irq;
      tick();
      check($sformatf("vec%0d ui", k),  {16'h0, ui16}, {16'h0, tbl[k].ui});
      check($sformatf("vec%0d rd", k),  rd16,          tbl[k].rd);
      check($sformatf("vec%0d req", k), {31'h0, req16}, {31'h0, tbl[k].req});
    end

    // narrow build: all-ones enable write reads back only the implemented bits
    rst = 0; we = 1; wa = BASE; wd = 32'hFFFF_FFFF; re = 1; ra = BASE; irq = 16'h0;
    tick();
    check("s4 enable readback", rd4, 32'h0000_000F);
    check("s16 enable readback", rd16, 32'h0000_FFFF);
    check("s4 ui upper bits", {20'h0, ui4[15:4]}, 32'h0);
    we = 1; wa = BASE+1; wd = 32'hFFFF_FFFF; ra = BASE+1;
    tick();
    check("s4 mode readback", rd4, 32'h0000_000F);

    // randomised traffic against the model, both widths
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      we  = ($urandom_range(0, 3) == 0);
      wa  = BASE + 12'($urandom_range(0, 5));
      wd  = ($urandom_range(0, 1) == 0) ? $urandom : {16'h0, 16'($urandom) & 16'($urandom)};
      re  = ($urandom_range(0, 4) != 0);
      ra  = BASE - 12'd1 + 12'($urandom_range(0, 5));
      irq = irq ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      tick();
      check("rnd ui16",  {16'h0, ui16}, {16'h0, m_pend & m_en});
      check("rnd rd16",  rd16, model_read());
      check("rnd req16", {31'h0, req16}, {31'h0, model_req()});
      check("rnd ui4",   {16'h0, ui4}, {28'h0, m_pend[3:0] & m_en[3:0]});
      check("rnd rd4",   rd4, model_read() & 32'hF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
